// File: rtl/dac_spi_driver_if.sv
// Sample stream from the waveform generator into the DAC SPI driver:
// 8-bit code, one-cycle update strobe and an accept enable.
interface dac_spi_driver_if;
  logic [7:0] sample_i;
  logic       sample_valid_i;
  logic       enable_i;

  modport master (
    output sample_i,
    output sample_valid_i,
    output enable_i
  );

  modport slave (
    input sample_i,
    input sample_valid_i,
    input enable_i
  );
endinterface

// File: rtl/dac_spi_driver.sv
// Serialises 8-bit DAC codes into 16-bit mode-0 SPI frames, with a
// one-deep pending buffer and a saturating overrun counter.
module dac_spi_driver #(
  parameter int         CLK_DIV = 4,
  parameter logic [3:0] CMD     = 4'b0011
) (
  input  logic              caravel_wb_clk_i,
  input  logic              caravel_wb_rst_i,
  dac_spi_driver_if.slave   smp,
  output logic              spi_sclk_o,
  output logic              spi_mosi_o,
  output logic              spi_cs_n_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [7:0]        overrun_count_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DLAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    TAIL,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] div;
  logic [3:0]    nbit;
  logic [14:0]   shreg;
  logic [7:0]    pend_data;
  logic          pend_v;

  logic consume;
  logic take;
  logic div_end;

  assign consume = (state == IDLE) && pend_v;
  assign take    = smp.sample_valid_i && smp.enable_i;
  assign div_end = (div == DLAST);
  assign busy_o  = (state != IDLE) || pend_v;

  // A strobe landing on the consume edge refills the buffer without loss.
  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      pend_v          <= 1'b0;
      pend_data       <= 8'h00;
      overrun_count_o <= 8'h00;
    end else if (!smp.enable_i) begin
      pend_v <= 1'b0;
    end else if (take) begin
      pend_data <= smp.sample_i;
      pend_v    <= 1'b1;
      if (pend_v && !consume && overrun_count_o != 8'hff)
        overrun_count_o <= overrun_count_o + 8'd1;
    end else if (consume) begin
      pend_v <= 1'b0;
    end
  end

  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      state        <= IDLE;
      div          <= '0;
      nbit         <= 4'd0;
      shreg        <= 15'd0;
      spi_sclk_o   <= 1'b0;
      spi_mosi_o   <= 1'b0;
      spi_cs_n_o   <= 1'b1;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (state != IDLE)
        div <= div_end ? '0 : div + CW'(1);
      unique case (state)
        IDLE: begin
          if (pend_v) begin
            shreg      <= {CMD[2:0], pend_data, 4'b0000};
            spi_mosi_o <= CMD[3];
            spi_cs_n_o <= 1'b0;
            nbit       <= 4'd0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (div_end) begin
            spi_sclk_o <= 1'b1;
            state      <= HIGH;
          end
        end
        HIGH: begin
          if (div_end) begin
            spi_sclk_o <= 1'b0;
            if (nbit == 4'd15) begin
              state <= TAIL;
            end else begin
              nbit       <= nbit + 4'd1;
              spi_mosi_o <= shreg[14];
              shreg      <= {shreg[13:0], 1'b0};
              state      <= LOW;
            end
          end
        end
        LOW: begin
          if (div_end) begin
            spi_sclk_o <= 1'b1;
            state      <= HIGH;
          end
        end
        TAIL: begin
          if (div_end) begin
            spi_cs_n_o   <= 1'b1;
            spi_mosi_o   <= 1'b0;
            frame_done_o <= 1'b1;
            state        <= GAP;
          end
        end
        GAP: begin
          if (div_end)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
